// File: rtl/pu_mac_array.sv
// pu_mac_array: NUM_PE signed MAC lanes with a shared per-entry weight, fed from a show-ahead FIFO.
// Each lane's result is scaled and saturated, then optionally passed through ReLU and 2:1 max-pooling.
// Ports:
//   clk, reset (async, active-low)
//   cfg_kernel_len/cfg_num_out/cfg_relu_en/cfg_pool_en : job configuration, latched on an accepted start
//   start                                              : begins a job from IDLE
//   vecgen_wr_req/_data/_weight, vecgen_ready          : input FIFO push side (ready = not full)
//   out_valid/out_ready/out_data                       : result handshake (lane packing same as input)
//   busy, done                                         : job status; done is a one-cycle end-of-job pulse
module pu_mac_array #(
    parameter int OP_WIDTH   = 16,
    parameter int NUM_PE     = 4,
    parameter int ACC_WIDTH  = 40,
    parameter int FIFO_DEPTH = 8,
    parameter int FRAC_BITS  = 0,
    parameter int CNT_WIDTH  = 16,
    localparam int DATA_IN_WIDTH = OP_WIDTH * NUM_PE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CNT_WIDTH-1:0]     cfg_kernel_len,
    input  logic [CNT_WIDTH-1:0]     cfg_num_out,
    input  logic                     cfg_relu_en,
    input  logic                     cfg_pool_en,
    input  logic                     start,
    input  logic                     vecgen_wr_req,
    input  logic [DATA_IN_WIDTH-1:0] vecgen_wr_data,
    input  logic [OP_WIDTH-1:0]      vecgen_wr_weight,
    output logic                     vecgen_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_IN_WIDTH-1:0] out_data,
    output logic                     busy,
    output logic                     done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-OP_WIDTH+1){1'b0}}, {(OP_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-OP_WIDTH+1){1'b1}}, {(OP_WIDTH-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, ACC, FIN, OUT} state_e;
    state_e state_q, state_d;
    logic [DATA_IN_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic signed [OP_WIDTH-1:0] fifo_w_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] cnt_q;
    logic full, empty, push, pop;
    logic [CNT_WIDTH-1:0] klen_q, klen_d, nout_q, nout_d, kcnt_q, kcnt_d, ocnt_q, ocnt_d;
    logic relu_q, relu_d, pool_q, pool_d, half_q, half_d, done_q, done_d;
    logic signed [ACC_WIDTH-1:0] acc_q [NUM_PE];
    logic signed [ACC_WIDTH-1:0] acc_d [NUM_PE];
    logic signed [OP_WIDTH-1:0] pool_reg_q [NUM_PE];
    logic signed [OP_WIDTH-1:0] pool_reg_d [NUM_PE];
    logic [DATA_IN_WIDTH-1:0] out_q, out_d;
    logic signed [2*OP_WIDTH-1:0] prod [NUM_PE];
    logic signed [ACC_WIDTH-1:0] shifted [NUM_PE];
    logic signed [OP_WIDTH-1:0] sat [NUM_PE];
    logic signed [OP_WIDTH-1:0] r [NUM_PE];
    logic signed [OP_WIDTH-1:0] mx [NUM_PE];
    assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign empty = cnt_q == '0;
    assign pop = state_q == ACC && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside a pop.
    assign push = vecgen_wr_req && (!full || pop);
    assign vecgen_ready = !full;
    assign out_valid = state_q == OUT;
    assign out_data = out_q;
    assign busy = state_q != IDLE;
    assign done = done_q;
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= vecgen_wr_data;
            fifo_w_q[wr_ptr_q] <= vecgen_wr_weight;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_comb begin
        for (int i = 0; i < NUM_PE; i++) begin
            prod[i] = (2*OP_WIDTH)'($signed(fifo_data_q[rd_ptr_q][i*OP_WIDTH +: OP_WIDTH])) * (2*OP_WIDTH)'(fifo_w_q[rd_ptr_q]);
            shifted[i] = acc_q[i] >>> FRAC_BITS;
            sat[i] = shifted[i] > SAT_MAX ? SAT_MAX[OP_WIDTH-1:0] : shifted[i] < SAT_MIN ? SAT_MIN[OP_WIDTH-1:0] : shifted[i][OP_WIDTH-1:0];
            r[i] = relu_q && sat[i][OP_WIDTH-1] ? '0 : sat[i];
            mx[i] = pool_reg_q[i] > r[i] ? pool_reg_q[i] : r[i];
        end
    end
    always_comb begin
        state_d = state_q;
        klen_d = klen_q;
        nout_d = nout_q;
        relu_d = relu_q;
        pool_d = pool_q;
        kcnt_d = kcnt_q;
        ocnt_d = ocnt_q;
        half_d = half_q;
        done_d = 1'b0;
        acc_d = acc_q;
        pool_reg_d = pool_reg_q;
        out_d = out_q;
        case (state_q)
            IDLE: if (start) begin
                klen_d = cfg_kernel_len == '0 ? CNT_WIDTH'(1) : cfg_kernel_len;
                nout_d = cfg_num_out;
                relu_d = cfg_relu_en;
                pool_d = cfg_pool_en;
                kcnt_d = '0;
                ocnt_d = '0;
                half_d = 1'b0;
                for (int i = 0; i < NUM_PE; i++) acc_d[i] = '0;
                if (cfg_num_out == '0) done_d = 1'b1;
                else state_d = ACC;
            end
            ACC: if (pop) begin
                for (int i = 0; i < NUM_PE; i++) acc_d[i] = acc_q[i] + ACC_WIDTH'(prod[i]);
                kcnt_d = kcnt_q + CNT_WIDTH'(1);
                if (kcnt_d == klen_q) begin
                    kcnt_d = '0;
                    state_d = FIN;
                end
            end
            FIN: begin
                for (int i = 0; i < NUM_PE; i++) acc_d[i] = '0;
                if (pool_q && !half_q) begin
                    pool_reg_d = r;
                    half_d = 1'b1;
                    state_d = ACC;
                end else begin
                    for (int i = 0; i < NUM_PE; i++) out_d[i*OP_WIDTH +: OP_WIDTH] = pool_q ? mx[i] : r[i];
                    half_d = 1'b0;
                    state_d = OUT;
                end
            end
            OUT: if (out_ready) begin
                ocnt_d = ocnt_q + CNT_WIDTH'(1);
                done_d = ocnt_d == nout_q;
                state_d = ocnt_d == nout_q ? IDLE : ACC;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            klen_q <= '0;
            nout_q <= '0;
            kcnt_q <= '0;
            ocnt_q <= '0;
            relu_q <= 1'b0;
            pool_q <= 1'b0;
            half_q <= 1'b0;
            done_q <= 1'b0;
            out_q <= '0;
            for (int i = 0; i < NUM_PE; i++) begin
                acc_q[i] <= '0;
                pool_reg_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            klen_q <= klen_d;
            nout_q <= nout_d;
            kcnt_q <= kcnt_d;
            ocnt_q <= ocnt_d;
            relu_q <= relu_d;
            pool_q <= pool_d;
            half_q <= half_d;
            done_q <= done_d;
            out_q <= out_d;
            acc_q <= acc_d;
            pool_reg_q <= pool_reg_d;
        end
    end
endmodule

// File: tb/tb_pu_mac_array.sv
// tb_pu_mac_array: directed bench for pu_mac_array; drives and samples on the falling clock edge.
module tb_pu_mac_array;
    logic        clk;
    logic        reset;
    logic [15:0] cfg_kernel_len;
    logic [15:0] cfg_num_out;
    logic        cfg_relu_en;
    logic        cfg_pool_en;
    logic        start;
    logic        vecgen_wr_req;
    logic [63:0] vecgen_wr_data;
    logic [15:0] vecgen_wr_weight;
    logic        vecgen_ready;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;
    logic        done;
    int          errors = 0;
    int          checks = 0;

    pu_mac_array dut (
        .clk(clk), .reset(reset),
        .cfg_kernel_len(cfg_kernel_len), .cfg_num_out(cfg_num_out),
        .cfg_relu_en(cfg_relu_en), .cfg_pool_en(cfg_pool_en), .start(start),
        .vecgen_wr_req(vecgen_wr_req), .vecgen_wr_data(vecgen_wr_data),
        .vecgen_wr_weight(vecgen_wr_weight), .vecgen_ready(vecgen_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] d, input int w);
        vecgen_wr_req = 1'b1;
        vecgen_wr_data = d;
        vecgen_wr_weight = w[15:0];
        @(negedge clk);
        vecgen_wr_req = 1'b0;
    endtask

    task automatic do_start(input int kl, input int no, input logic relu, input logic pool);
        cfg_kernel_len = kl[15:0];
        cfg_num_out = no[15:0];
        cfg_relu_en = relu;
        cfg_pool_en = pool;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    endtask

    task automatic take(input string tag, input logic [63:0] exp);
        wait_valid(tag);
        chk(tag, out_data, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        cfg_kernel_len = '0;
        cfg_num_out = '0;
        cfg_relu_en = 1'b0;
        cfg_pool_en = 1'b0;
        start = 1'b0;
        vecgen_wr_req = 1'b0;
        vecgen_wr_data = '0;
        vecgen_wr_weight = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(vecgen_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Basic MAC with exact latency
        do_start(3, 1, 1'b0, 1'b0);
        chk("basic_busy", 64'(busy), 64'd1);
        push(pk(1, 2, 3, 4), 1);
        push(pk(1, 2, 3, 4), 2);
        push(pk(1, 2, 3, 4), 3);
        chk("basic_acc_novalid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("basic_fin_novalid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("basic_valid_t2", 64'(out_valid), 64'd1);
        chk("basic_data", out_data, pk(6, 12, 18, 24));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("basic_done", 64'(done), 64'd1);
        chk("basic_busy_low", 64'(busy), 64'd0);
        chk("basic_valid_low", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("basic_done_pulse", 64'(done), 64'd0);

        // ReLU and saturation
        do_start(2, 1, 1'b1, 1'b0);
        push(pk(-5, 32767, -32768, 1), 32767);
        push(pk(-5, 32767, -32768, 1), 32767);
        take("relu", pk(0, 32767, 0, 32767));
        chk("relu_done", 64'(done), 64'd1);
        do_start(2, 1, 1'b0, 1'b0);
        push(pk(-5, 32767, -32768, 1), 32767);
        push(pk(-5, 32767, -32768, 1), 32767);
        take("sat", pk(-32768, 32767, -32768, 32767));

        // Pooling: one output from two kernels
        do_start(1, 1, 1'b0, 1'b1);
        push(pk(5, -3, 7, 0), 1);
        push(pk(9, -8, 2, 0), 1);
        take("pool", pk(9, -3, 7, 0));
        chk("pool_done", 64'(done), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("pool_single", 64'(out_valid), 64'd0);
        end

        // FIFO fill in IDLE: entries 9 and 10 are dropped
        for (int i = 1; i <= 10; i++) begin
            vecgen_wr_req = 1'b1;
            vecgen_wr_data = pk(i, 2 * i, -i, 0);
            vecgen_wr_weight = 16'd1;
            @(negedge clk);
            if (i == 7) chk("fill_ready7", 64'(vecgen_ready), 64'd1);
            if (i == 8) chk("fill_full8", 64'(vecgen_ready), 64'd0);
        end
        vecgen_wr_req = 1'b0;
        chk("fill_drop", 64'(vecgen_ready), 64'd0);
        do_start(4, 2, 1'b0, 1'b0);
        wait_valid("bp1");
        for (int k = 0; k < 5; k++) begin
            vecgen_wr_req = k < 4;
            vecgen_wr_data = pk(11 + k, 2 * (11 + k), -(11 + k), 0);
            vecgen_wr_weight = 16'd1;
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_data", out_data, pk(10, 20, -10, 0));
            @(negedge clk);
        end
        vecgen_wr_req = 1'b0;
        chk("bp_no_pop_in_out", 64'(vecgen_ready), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_mid_done", 64'(done), 64'd0);
        push(pk(15, 30, -15, 0), 1);
        chk("full_pushpop", 64'(vecgen_ready), 64'd0);
        @(negedge clk);
        chk("pop_after_full", 64'(vecgen_ready), 64'd1);
        take("bp2", pk(26, 52, -26, 0));
        chk("bp_done", 64'(done), 64'd1);
        do_start(5, 1, 1'b0, 1'b0);
        take("drain", pk(65, 130, -65, 0));

        // num_out = 0
        do_start(3, 0, 1'b0, 1'b0);
        chk("nout0_done", 64'(done), 64'd1);
        chk("nout0_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("nout0_done_pulse", 64'(done), 64'd0);
        chk("nout0_busy2", 64'(busy), 64'd0);

        // kernel_len = 0 behaves as 1
        push(pk(3, -4, 5, 6), 7);
        do_start(0, 1, 1'b0, 1'b0);
        take("klen0", pk(21, -28, 35, 42));

        // Reset mid-job with entries queued
        push(pk(100, 100, 100, 100), 1);
        push(pk(100, 100, 100, 100), 1);
        push(pk(100, 100, 100, 100), 1);
        do_start(8, 1, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(vecgen_ready), 64'd1);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        push(pk(1, -1, 2, -2), 3);
        do_start(1, 1, 1'b0, 1'b0);
        take("post_reset", pk(3, -3, 6, -6));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pu_mac_array.md
Name: pu_mac_array

Overview:
Parametrised successor processing unit for the conv datapath. NUM_PE signed MAC lanes share one broadcast weight per cycle and take per-lane operands from the vector generator through an internal FIFO. Each lane accumulates a kernel of configurable length, then scales and saturates the result. Optional ReLU and 2:1 max-pooling are applied before a valid/ready output stage.

Parameters:
OP_WIDTH, 16, signed operand/result width per lane
NUM_PE, 4, number of MAC lanes
ACC_WIDTH, 40, signed accumulator width per lane (>= 2*OP_WIDTH)
FIFO_DEPTH, 8, input FIFO entries, power of 2, >= 2
FRAC_BITS, 0, arithmetic right shift applied to accumulator before saturation
CNT_WIDTH, 16, width of config counters
DATA_IN_WIDTH (localparam), OP_WIDTH*NUM_PE

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
cfg_kernel_len  in  CNT_WIDTH  MACs per kernel; 0 treated as 1; sampled on start
cfg_num_out  in  CNT_WIDTH  output vectors per job; sampled on start
cfg_relu_en  in  1  clamp negative results to 0; sampled on start
cfg_pool_en  in  1  output = lane-wise max of two consecutive kernel results; sampled on start
start  in  1  begin job; honoured only in IDLE
vecgen_wr_req  in  1  push one entry
vecgen_wr_data  in  DATA_IN_WIDTH  lane operands; lane i = bits [i*OP_WIDTH +: OP_WIDTH]
vecgen_wr_weight  in  OP_WIDTH  weight paired with this entry
vecgen_ready  out  1  FIFO not full
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts
out_data  out  DATA_IN_WIDTH  lane results, same packing as input
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job end

Behaviour:
- Reset: FIFO empty, all counters/accumulators/pool register 0, state IDLE. Outputs: vecgen_ready=1, out_valid=0, out_data=0, busy=0, done=0. Reset mid-job aborts the job and discards FIFO contents.
- FIFO: show-ahead. Push when vecgen_wr_req && !full. A push while full is dropped with no state change. Push and pop in the same cycle are legal whenever the FIFO is non-empty (count unchanged, including when full). Pushes are accepted in every state.
- States:
  - IDLE: on start, latch cfg and clear accumulators. If cfg_num_out==0, pulse done next cycle and stay IDLE; otherwise go to ACC.
  - ACC: each cycle the FIFO is non-empty, pop one entry and update acc[i] += sext(a[i]*w), with a full-precision signed product. When the pop count reaches kernel_len, go to FIN. An empty FIFO stalls with no change.
  - FIN (1 cycle): r[i] = sat_OP_WIDTH(acc[i] >>> FRAC_BITS), saturating to [-2^(OP_WIDTH-1), 2^(OP_WIDTH-1)-1]; then r[i] = max(r[i],0) if relu. Clear accumulators.
    - If pool_en and this is the first half: store r into pool_reg, return to ACC.
    - Otherwise load out_data with r (or lane-wise signed max(pool_reg, r) if pool_en) and go to OUT.
  - OUT: out_valid=1 and out_data held stable until out_ready. On handshake, increment the output count. If it equals num_out, pulse done and go to IDLE; otherwise go to ACC. No pops occur in FIN or OUT.
- Latency: the last pop of a kernel happens in cycle t, FIN is cycle t+1, and out_valid is first high in cycle t+2. done is asserted in the cycle after the final handshake, coincident with busy falling.
- Accumulator overflow wraps within ACC_WIDTH. Sizing ACC_WIDTH for the worst-case kernel is the configuring engineer's job.
- start outside IDLE is ignored. cfg inputs are ignored except on an accepted start.

Test Plan:
- Basic MAC: kernel_len=3, num_out=1, lanes a=[1,2,3,4] with weights 1,2,3 → out_data lanes [6,12,18,24], out_valid 2 cycles after third pop, then done pulse.
- ReLU and saturation: lanes [-5, 32767, -32768, 1] with weight 32767 and kernel_len=2, relu_en=1 → [0,32767,0,65534→32767]; with relu_en=0, lane 2 → -32768.
- Pooling: pool_en=1, kernel_len=1, num_out=1, entries (lanes [5,-3,7,0], w=1) then (lanes [9,-8,2,0], w=1) → [9,-3,7,0]; exactly one out_valid handshake.
- FIFO full/backpressure: in IDLE push 10 entries back-to-back → vecgen_ready low after 8 and entries 9–10 dropped. Start with kernel_len=4, num_out=2 and hold out_ready=0 for 5 cycles → out_data stable, no pops in OUT, second result uses entries 5–8.
- Boundaries: num_out=0 → done one cycle after start, busy stays 0. kernel_len=0 → behaves as 1. Simultaneous push+pop at full → count stays 8.
- Reset mid-job: assert reset during ACC with 3 entries queued → all outputs at reset values, vecgen_ready=1. A new job afterwards sees an empty FIFO.
